// File: rtl/command_serializer_if.sv
// Host-side command handshake and byte-stream outputs of command_serializer.
// The master modport is the side that issues commands and sinks bytes.
interface command_serializer_if;
    logic        i_valid;
    logic        o_ready;
    logic        i_write;
    logic [7:0]  i_addr;
    logic [31:0] i_value;
    logic        i_tx_ready;
    logic [7:0]  o_data;
    logic        o_dv;
    logic        o_busy;
    logic        o_done;

    modport master (
        output i_valid, i_write, i_addr, i_value, i_tx_ready,
        input  o_ready, o_data, o_dv, o_busy, o_done
    );

    modport slave (
        input  i_valid, i_write, i_addr, i_value, i_tx_ready,
        output o_ready, o_data, o_dv, o_busy, o_done
    );
endinterface

// File: rtl/command_serializer.sv
// Serializes one register command into the 6-byte cmd/addr/value frame parsed by
// command_controller, one o_dv strobe per byte with a programmable idle gap.
module command_serializer #(
    parameter int unsigned GAP_CYCLES = 10,
    parameter logic [7:0]  READ_CMD   = 8'h00,
    parameter logic [7:0]  WRITE_CMD  = 8'hAA
) (
    input  logic                 clk,
    input  logic                 i_reset_n,
    command_serializer_if.slave  bus
);
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    localparam logic [7:0] GAP_LOAD   = 8'(GAP_CYCLES);
    localparam logic [2:0] LAST_INDEX = 3'd5;

    state_t      state_r, state_s;
    logic [47:0] frame_r, frame_s;
    logic [2:0]  index_r, index_s;
    logic [7:0]  count_r, count_s;
    logic [7:0]  data_r, data_s;
    logic        dv_r, dv_s;
    logic        done_r, done_s;

    // Byte 0 is the command byte; value bytes follow MSB first.
    function automatic logic [7:0] frame_byte(input logic [47:0] frame, input logic [2:0] index);
        logic [7:0] sel;
        case (index)
            3'd0:    sel = frame[47:40];
            3'd1:    sel = frame[39:32];
            3'd2:    sel = frame[31:24];
            3'd3:    sel = frame[23:16];
            3'd4:    sel = frame[15:8];
            3'd5:    sel = frame[7:0];
            default: sel = 8'h00;
        endcase
        return sel;
    endfunction

    // Next-state and next-output logic; o_data holds unless a byte is strobed.
    always_comb begin
        state_s = state_r;
        frame_s = frame_r;
        index_s = index_r;
        count_s = count_r;
        data_s  = data_r;
        dv_s    = 1'b0;
        done_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (bus.i_valid) begin
                    frame_s = {(bus.i_write ? WRITE_CMD : READ_CMD), bus.i_addr, bus.i_value};
                    index_s = 3'd0;
                    state_s = ST_SEND;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_SEND: begin
                if (bus.i_tx_ready) begin
                    data_s  = frame_byte(frame_r, index_r);
                    dv_s    = 1'b1;
                    count_s = GAP_LOAD;
                    state_s = ST_GAP;
                end else begin
                    state_s = ST_SEND;
                end
            end
            ST_GAP: begin
                if (count_r != 8'd0) begin
                    count_s = count_r - 8'd1;
                end else if (index_r != LAST_INDEX) begin
                    index_s = index_r + 3'd1;
                    state_s = ST_SEND;
                end else begin
                    state_s = ST_IDLE;
                    done_s  = 1'b1;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset aborts any frame in flight.
    always_ff @(posedge clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_r <= ST_IDLE;
            frame_r <= 48'h0;
            index_r <= 3'd0;
            count_r <= 8'd0;
            data_r  <= 8'h00;
            dv_r    <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            frame_r <= frame_s;
            index_r <= index_s;
            count_r <= count_s;
            data_r  <= data_s;
            dv_r    <= dv_s;
            done_r  <= done_s;
        end
    end

    assign bus.o_ready = (state_r == ST_IDLE);
    assign bus.o_busy  = (state_r != ST_IDLE);
    assign bus.o_data  = data_r;
    assign bus.o_dv    = dv_r;
    assign bus.o_done  = done_r;
endmodule

// File: tb/tb_command_serializer.sv
// Directed bench for command_serializer: one instance with a 10-cycle gap, one with no gap.
module tb_command_serializer;
    typedef struct {
        logic        write;
        logic [7:0]  addr;
        logic [31:0] value;
        logic [47:0] frame;
    } vec_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   cyc   = 0;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    command_serializer_if a_if();
    command_serializer_if b_if();

    command_serializer #(.GAP_CYCLES(10), .READ_CMD(8'h00), .WRITE_CMD(8'hAA)) dut_a (
        .clk(clk), .i_reset_n(rst_n), .bus(a_if.slave));
    command_serializer #(.GAP_CYCLES(0), .READ_CMD(8'h00), .WRITE_CMD(8'hAA)) dut_b (
        .clk(clk), .i_reset_n(rst_n), .bus(b_if.slave));

    logic [7:0] byte_a [64];
    int         scyc_a [64];
    int         done_a [16];
    int         n_a = 0, nd_a = 0, overlap_a = 0;
    logic [7:0] byte_b [64];
    int         scyc_b [64];
    int         done_b [16];
    int         n_b = 0, nd_b = 0, overlap_b = 0, consec_b = 0;
    logic       prev_dv_b = 1'b0;

    // Byte/done monitor, sampled on the falling edge
    always @(negedge clk) begin
        if (a_if.o_dv && n_a < 64) begin
            byte_a[n_a] = a_if.o_data; scyc_a[n_a] = cyc; n_a = n_a + 1;
        end
        if (a_if.o_done && nd_a < 16) begin
            done_a[nd_a] = cyc; nd_a = nd_a + 1;
        end
        if (a_if.o_dv && a_if.o_done) overlap_a = overlap_a + 1;
        if (b_if.o_dv && n_b < 64) begin
            byte_b[n_b] = b_if.o_data; scyc_b[n_b] = cyc; n_b = n_b + 1;
        end
        if (b_if.o_done && nd_b < 16) begin
            done_b[nd_b] = cyc; nd_b = nd_b + 1;
        end
        if (b_if.o_dv && b_if.o_done) overlap_b = overlap_b + 1;
        if (b_if.o_dv && prev_dv_b) consec_b = consec_b + 1;
        prev_dv_b = b_if.o_dv;
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic send(input bit use_b, input logic wr, input logic [7:0] addr,
                        input logic [31:0] value, input bit keep, output int acc);
        bit got = 1'b0;
        logic rdy;
        acc = 0;
        tick();
        if (use_b) begin
            b_if.i_valid = 1'b1; b_if.i_write = wr; b_if.i_addr = addr; b_if.i_value = value;
        end else begin
            a_if.i_valid = 1'b1; a_if.i_write = wr; a_if.i_addr = addr; a_if.i_value = value;
        end
        for (int k = 0; k < 200 && !got; k++) begin
            rdy = use_b ? b_if.o_ready : a_if.o_ready;
            if (rdy) begin
                @(posedge clk);
                #1;
                acc = cyc;
                got = 1'b1;
            end else begin
                tick();
            end
        end
        check("accept_timeout", got, 1'b1);
        tick();
        if (!keep) begin
            if (use_b) b_if.i_valid = 1'b0;
            else       a_if.i_valid = 1'b0;
        end
    endtask

    task automatic wait_done(input bit use_b, input int target);
        int k = 0;
        while ((use_b ? nd_b : nd_a) < target && k < 400) begin
            tick();
            k++;
        end
        check("done_timeout", (use_b ? nd_b : nd_a) >= target, 1'b1);
    endtask

    task automatic wait_bytes(input int target);
        int k = 0;
        while (n_a < target && k < 200) begin
            tick();
            k++;
        end
        check("strobe_timeout", n_a >= target, 1'b1);
    endtask

    task automatic check_frame(input bit use_b, input int base, input int didx, input logic [47:0] exp,
                               input int gap, input int first, input int bp_i, input int bp_extra);
        logic [7:0] got;
        int t0, t1, extra;
        for (int i = 0; i < 6; i++) begin
            got = use_b ? byte_b[base + i] : byte_a[base + i];
            check($sformatf("byte%0d", i), got, exp[47 - 8 * i -: 8]);
        end
        check("first_strobe_cycle", use_b ? scyc_b[base] : scyc_a[base], first);
        for (int i = 1; i < 6; i++) begin
            t0 = use_b ? scyc_b[base + i - 1] : scyc_a[base + i - 1];
            t1 = use_b ? scyc_b[base + i] : scyc_a[base + i];
            extra = (i == bp_i) ? bp_extra : 0;
            check($sformatf("spacing%0d", i), t1 - t0, gap + 2 + extra);
        end
        t1 = use_b ? done_b[didx] : done_a[didx];
        t0 = use_b ? scyc_b[base + 5] : scyc_a[base + 5];
        check("done_latency", t1 - t0, gap + 1);
    endtask

    initial begin
        vec_t vecs [4];
        int acc, base, dbase, d1;
        vecs[0] = '{1'b0, 8'h12, 32'h12345678, 48'h00_12_12_34_56_78};
        vecs[1] = '{1'b1, 8'h21, 32'h87654321, 48'hAA_21_87_65_43_21};
        vecs[2] = '{1'b1, 8'hFF, 32'h00000000, 48'hAA_FF_00_00_00_00};
        vecs[3] = '{1'b0, 8'h00, 32'hFFFFFFFF, 48'h00_00_FF_FF_FF_FF};

        a_if.i_valid = 1'b0; a_if.i_write = 1'b0; a_if.i_addr = 8'h00;
        a_if.i_value = 32'h0; a_if.i_tx_ready = 1'b1;
        b_if.i_valid = 1'b0; b_if.i_write = 1'b0; b_if.i_addr = 8'h00;
        b_if.i_value = 32'h0; b_if.i_tx_ready = 1'b1;

        repeat (3) tick();
        check("reset_ready", a_if.o_ready, 1'b1);
        check("reset_busy", a_if.o_busy, 1'b0);
        check("reset_dv", a_if.o_dv, 1'b0);
        check("reset_done", a_if.o_done, 1'b0);
        check("reset_data", a_if.o_data, 8'h00);
        rst_n = 1'b1;
        tick();

        for (int v = 0; v < 4; v++) begin
            base = n_a; dbase = nd_a;
            send(1'b0, vecs[v].write, vecs[v].addr, vecs[v].value, 1'b0, acc);
            wait_done(1'b0, dbase + 1);
            check("ready_at_done", a_if.o_ready, 1'b1);
            check_frame(1'b0, base, dbase, vecs[v].frame, 10, acc + 1, -1, 0);
            if (vecs[v].write) begin
                check("loop_w_addr", byte_a[base + 1], vecs[v].addr);
                check("loop_w_data", {byte_a[base + 2], byte_a[base + 3], byte_a[base + 4], byte_a[base + 5]},
                      vecs[v].value);
            end
        end

        // Backpressure: stall 7 SEND cycles in front of byte 2
        base = n_a; dbase = nd_a;
        send(1'b0, 1'b1, 8'h3C, 32'hA5A55A5A, 1'b0, acc);
        wait_bytes(base + 2);
        a_if.i_tx_ready = 1'b0;
        repeat (18) tick();
        check("bp_no_strobe", n_a - base, 2);
        a_if.i_tx_ready = 1'b1;
        wait_done(1'b0, dbase + 1);
        check_frame(1'b0, base, dbase, 48'hAA_3C_A5_A5_5A_5A, 10, acc + 1, 2, 7);

        // Back-to-back: valid held high, second command accepted on the done cycle
        base = n_a; dbase = nd_a;
        send(1'b0, 1'b0, 8'h44, 32'h01020304, 1'b1, acc);
        a_if.i_write = 1'b1; a_if.i_addr = 8'h55; a_if.i_value = 32'hCAFEF00D;
        repeat (20) tick();
        check("ready_low_while_busy", a_if.o_ready, 1'b0);
        check("busy_while_busy", a_if.o_busy, 1'b1);
        wait_done(1'b0, dbase + 1);
        d1 = done_a[dbase];
        tick();
        a_if.i_valid = 1'b0;
        wait_done(1'b0, dbase + 2);
        repeat (5) tick();
        check_frame(1'b0, base, dbase, 48'h00_44_01_02_03_04, 10, acc + 1, -1, 0);
        check_frame(1'b0, base + 6, dbase + 1, 48'hAA_55_CA_FE_F0_0D, 10, d1 + 2, -1, 0);
        check("b2b_byte_total", n_a - base, 12);

        // Reset mid-frame, right after the 3rd strobe
        base = n_a; dbase = nd_a;
        send(1'b0, 1'b1, 8'h77, 32'h11223344, 1'b0, acc);
        wait_bytes(base + 3);
        check("dv_before_reset", a_if.o_dv, 1'b1);
        rst_n = 1'b0;
        #1;
        check("rst_dv", a_if.o_dv, 1'b0);
        check("rst_done", a_if.o_done, 1'b0);
        check("rst_data", a_if.o_data, 8'h00);
        check("rst_ready", a_if.o_ready, 1'b1);
        a_if.i_valid = 1'b1;
        repeat (3) tick();
        a_if.i_valid = 1'b0;
        rst_n = 1'b1;
        repeat (40) tick();
        check("rst_no_more_strobes", n_a - base, 3);
        check("rst_no_done", nd_a - dbase, 0);
        base = n_a; dbase = nd_a;
        send(1'b0, 1'b0, 8'h9A, 32'hFEDCBA98, 1'b0, acc);
        wait_done(1'b0, dbase + 1);
        check_frame(1'b0, base, dbase, 48'h00_9A_FE_DC_BA_98, 10, acc + 1, -1, 0);

        // Zero-gap instance
        send(1'b1, 1'b1, 8'h05, 32'hDEADBEEF, 1'b0, acc);
        wait_done(1'b1, 1);
        check_frame(1'b1, 0, 0, 48'hAA_05_DE_AD_BE_EF, 0, acc + 1, -1, 0);
        check("gap0_no_consecutive_dv", consec_b, 0);

        check("no_dv_done_overlap_a", overlap_a, 0);
        check("no_dv_done_overlap_b", overlap_b, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/command_serializer.md
# command_serializer

Transmit-side counterpart of `command_controller`. Accepts one register command (read/write, 8-bit address, 32-bit value) through a valid/ready handshake and serializes it into the 6-byte command frame that `command_controller` parses: cmd, addr, value[31:24], value[23:16], value[15:8], value[7:0]. Each byte is presented on `o_data` with a one-cycle `o_dv` strobe. Sits between host-side command logic and the byte transmitter (UART TX or direct loopback into `command_controller`).

## Interface

- `GAP_CYCLES`, 10: minimum idle cycles after each `o_dv` strobe before the next byte is considered; legal range 0..255.
- `READ_CMD`, 8'h00: command byte emitted when `i_write`=0.
- `WRITE_CMD`, 8'hAA: command byte emitted when `i_write`=1.

- `clk`  in  1  single clock; all logic on rising edge.
- `i_reset_n`  in  1  asynchronous, active-low reset.
- `i_valid`  in  1  command request valid.
- `o_ready`  out  1  block idle and able to accept a command.
- `i_write`  in  1  1 = write command, 0 = read command.
- `i_addr`  in  8  register address.
- `i_value`  in  32  value field; sent for reads as well.
- `i_tx_ready`  in  1  downstream byte sink can take a byte; tie high for direct loopback.
- `o_data`  out  8  current frame byte.
- `o_dv`  out  1  one-cycle strobe, `o_data` valid.
- `o_busy`  out  1  frame in progress.
- `o_done`  out  1  one-cycle pulse, frame fully sent.

## Operation

- States: IDLE, SEND, GAP.
- IDLE: `o_ready`=1. On `i_valid`&&`o_ready` at an edge, capture cmd byte (per `i_write`), `i_addr` and `i_value` into a 48-bit shift/hold register; byte index := 0; go to SEND. Later input changes have no effect on the frame.
- SEND: at an edge with `i_tx_ready`=1, set `o_data` := byte[index], `o_dv` := 1, load gap counter with `GAP_CYCLES`, go to GAP. With `i_tx_ready`=0, hold in SEND with `o_dv`=0, unbounded.
- GAP: `o_dv` := 0. Counter nonzero: decrement. Counter zero: index<5 → index+1, go to SEND; index==5 → go to IDLE, `o_done` := 1 for one cycle.
- `o_ready` = (state==IDLE), combinational from state. `o_busy` = !`o_ready`.
- `o_data` holds the last byte sent until the next strobe; it never changes while `o_dv`=0 except at reset.
- `i_valid` while busy is ignored; the requester holds it until `o_ready`.
- Byte order is fixed MSB-first: the value bytes go from value[31:24] to value[7:0].

## Timing

- Reset (asynchronous, `i_reset_n`=0): state IDLE, index 0, counter 0, `o_data`=8'h00, `o_dv`=0, `o_done`=0, `o_busy`=0, `o_ready`=1. No command is accepted while reset is asserted.
- Reset mid-frame: the frame is aborted immediately. No `o_done` pulse, no further strobes. The receiving `command_controller` must be reset alongside.
- Accept at edge E0 → first `o_dv` at E1 (if `i_tx_ready`=1), high for the E1–E2 cycle.
- `i_tx_ready` held high: strobe spacing is exactly `GAP_CYCLES`+2 cycles. The last strobe is at E1+5·(`GAP_CYCLES`+2).
- `o_done` is asserted at the edge `GAP_CYCLES`+1 cycles after the last strobe. `o_ready` rises at the same edge.
- A new command may be accepted on the `o_done` cycle; its first strobe follows one edge later.
- `GAP_CYCLES`=0: GAP lasts one cycle; spacing is 2 cycles; `o_dv` is never high on two consecutive cycles.
- `i_tx_ready` is sampled only in SEND. Deasserting it during GAP only delays the following byte.
- `o_dv` and `o_done` are never asserted in the same cycle.

## Test plan

- Read, `GAP_CYCLES`=10, `i_tx_ready`=1: addr 8'h12, value 32'h12345678 → bytes 00,12,12,34,56,78 with strobes 12 cycles apart, then one `o_done` pulse 11 cycles after the last strobe.
- Write loopback into `command_controller`: addr 8'h21, value 32'h87654321 → frame AA,21,87,65,43,21. `command_controller` pulses `w_en` with `w_addr`=8'h21 and `w_data`=32'h87654321.
- Backpressure: `i_tx_ready`=0 for 7 cycles while in SEND before byte 2 → no strobe during the stall. Byte 2 strobes at the first edge with `i_tx_ready`=1; byte sequence unchanged.
- Back-to-back: `i_valid` held high with two different commands → second accepted exactly at the `o_done` cycle. `i_valid` while busy is ignored (`o_ready`=0). No byte is lost or duplicated.
- Reset mid-frame: assert `i_reset_n`=0 after the 3rd strobe → `o_dv`, `o_done` and `o_data` go to 0 asynchronously and `o_ready`=1. A fresh command after reset is sent complete.
- `GAP_CYCLES`=0: write 8'h05/32'hDEADBEEF → strobes every 2 cycles (AA,05,DE,AD,BE,EF), `o_done` 1 cycle after the last strobe.
